// File: rtl/pipe_dmem_responder.sv
// Wait-state data-memory responder for the MEM stage.
// One access is accepted at a time and held for WAIT_CYCLES cycles. Completion
// is flagged with a one-cycle ready pulse. While an access is outstanding, stall
// holds the pipeline frozen.
module pipe_dmem_responder #(
  parameter int DEPTH_LOG2  = 5,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic        stall
);

  localparam int          DEPTH = 1 << DEPTH_LOG2;
  localparam int          AW    = DEPTH_LOG2 + 2;
  localparam logic [3:0]  WAIT4 = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [AW-1:0]     addr_q;
  logic [31:0]       wdata_q;
  logic              ready_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [31:0]       mem_q [DEPTH];

  // The access that completes this cycle. With zero wait states the FSM goes
  // straight from IDLE to DONE, so the live inputs are used before they are latched.
  logic                  acc_we;
  logic [AW-1:0]         acc_addr;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic                  acc_mis;
  logic                  enter_done;
  logic                  commit_wr;
  logic                  unused_addr_hi;

  assign acc_we     = (state_q == IDLE) ? we : we_q;
  assign acc_addr   = (state_q == IDLE) ? addr[AW-1:0] : addr_q;
  assign acc_idx    = acc_addr[AW-1:2];
  assign acc_mis    = |acc_addr[1:0];
  assign enter_done = ((state_q == IDLE) && req && (WAIT_CYCLES == 0)) ||
                      ((state_q == BUSY) && (cnt_q == 4'd1));
  // The store lands on the edge that leaves DONE. A reset during the access therefore discards it.
  assign commit_wr  = (state_q == DONE) && we_q && (addr_q[1:0] == 2'b00);
  // Upper address bits alias onto the same words and are deliberately dropped.
  assign unused_addr_hi = ^addr[31:AW];

  assign ready = ready_q;
  assign rdata = rdata_q;
  assign err   = err_q;
  assign stall = req & ~ready_q;

  // Access FSM: latch request in IDLE, count down in BUSY, pulse outputs in DONE
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      ready_q <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      if (enter_done) begin
        ready_q <= 1'b1;
        err_q   <= acc_mis;
        rdata_q <= (!acc_we && !acc_mis) ? mem_q[acc_idx] : 32'd0;
      end
      case (state_q)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= addr[AW-1:0];
            wdata_q <= wdata;
            cnt_q   <= WAIT4;
            state_q <= (WAIT_CYCLES > 0) ? BUSY : DONE;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Word storage: cleared on reset, written when an aligned store retires
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else if (commit_wr) begin
      mem_q[addr_q[AW-1:2]] <= wdata_q;
    end
  end

endmodule
